// File: rtl/rr_scheduler.sv
// rr_scheduler: merges CHANNELS valid/ready input streams onto one registered
// output stream, tagging each word with its source channel.
// Default build: work-conserving round-robin that skips idle channels.
// SCHED_TDM_EN: legacy fixed-slot TDM mode. The pointer advances every cycle,
// and only the channel it names can be granted.
module rr_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [$clog2(CHANNELS)-1:0]    out_chan,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int unsigned CW = $clog2(CHANNELS);

  logic [CW-1:0]         ptr;
  logic [CW-1:0]         grant;
  logic                  found;
  logic                  load_en;
  logic [DATA_WIDTH-1:0] words [CHANNELS];

  // Wrap is modulo CHANNELS, so non-power-of-two counts never reach an unused index
  function automatic logic [CW-1:0] next_chan(input logic [CW-1:0] c);
    return (32'(c) == CHANNELS - 1) ? '0 : CW'(32'(c) + 1);
  endfunction

  assign load_en = !out_valid || out_ready;

  // Unpack the flat input bus into per-channel words
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      words[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef SCHED_TDM_EN
  // Only the slot owner may be granted
  always_comb begin
    found = in_valid[ptr];
    grant = ptr;
  end
`else
  int unsigned idx;

  // First valid channel in search order ptr, ptr+1, ... wrapping at CHANNELS
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && in_valid[CW'(idx)]) begin
        found = 1'b1;
        grant = CW'(idx);
      end
    end
  end
`endif

  // Accept only the granted channel, and only when the output register can load.
  // Held at zero while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (rst_n && found && load_en) in_ready[grant] = 1'b1;
  end

  // Output register and priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
`ifdef SCHED_TDM_EN
      ptr <= next_chan(ptr);
      if (load_en) begin
        if (found) begin
          out_data  <= words[grant];
          out_chan  <= grant;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
`else
      if (load_en) begin
        if (found) begin
          out_data  <= words[grant];
          out_chan  <= grant;
          out_valid <= 1'b1;
          ptr       <= next_chan(grant);
        end else begin
          out_valid <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: doc/rr_scheduler.md
# rr_scheduler

Parametrised, work-conserving round-robin scheduler that merges CHANNELS independent valid/ready input streams onto one registered output stream. It is the successor to the fixed 4-input rotating-slot scheduler: channel count and width are parameters, every side uses a handshake, and idle channels are skipped. It sits between the per-channel request registers and the shared downstream datapath. Each output word carries its source channel index.

## Interface
- DATA_WIDTH, 16, width of each data word
- CHANNELS, 4, number of input channels; ≥2; need not be a power of two
- CW (localparam), $clog2(CHANNELS), channel-index width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  CHANNELS*DATA_WIDTH  packed words; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  CHANNELS  per-channel word-valid
- in_ready  output  CHANNELS  per-channel accept; combinational; one-hot or zero
- out_data  output  DATA_WIDTH  registered selected word
- out_chan  output  CW  registered source channel of out_data
- out_valid  output  1  registered; out_data/out_chan hold a word
- out_ready  input  1  downstream accepts when high with out_valid

## Operation
- Transfer on input i when in_valid[i] && in_ready[i] at a rising edge. Transfer on output when out_valid && out_ready.
- load_en = !out_valid || out_ready.
- Pointer ptr (CW bits) names the highest-priority channel. Search order: ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1. Wrap is explicit modulo CHANNELS, not modulo 2^CW.
- Grant g is the first channel in search order with in_valid high. in_ready[g] = load_en; all other in_ready bits are 0. If no in_valid bit is high, in_ready = 0.
- On a grant transfer:
  - out_data <= word g, out_chan <= g, out_valid <= 1.
  - ptr <= (g == CHANNELS-1) ? 0 : g+1.
- If load_en is high and there is no grant: out_valid <= 0, and out_data/out_chan hold their values.
- If load_en is low: the output registers and ptr hold, and in_ready is 0 (backpressure).
- An idle channel costs zero cycles (work-conserving). A continuously valid channel waits at most CHANNELS-1 grants.
- in_ready does not depend combinationally on in_data. It depends on in_valid, out_valid and out_ready.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_chan=0, ptr=0, in_ready=0.
  - Reset takes effect immediately, even mid-stream. A pending output word is discarded.
  - Release is synchronous to the next clk edge.
- Latency: input transfer at edge N → out_valid high after edge N, visible in cycle N+1.
- Throughput: one word per cycle while out_ready is held high and any in_valid is high.
- Simultaneous output consume and new load in one cycle: the new word replaces the old one with no bubble.
- out_valid stays high and out_data/out_chan stay stable until consumed.

## Configuration
- SCHED_TDM_EN defined: legacy fixed-slot TDM mode.
  - ptr advances (ptr+1 mod CHANNELS) every cycle unconditionally after reset.
  - Only channel ptr may be granted: in_ready[ptr] = load_en && in_valid[ptr].
  - Idle slots are wasted; output timing is deterministic.
- SCHED_TDM_EN undefined: work-conserving round-robin as described above.
- The interface is identical in both builds.

## Test plan
- Reset, then all four channels valid with words 0xA000..0xA003 and out_ready=1 → output sequence chan 0,1,2,3,0 with data 0xA000,0xA001,0xA002,0xA003, one per cycle, each appearing 1 cycle after transfer.
- Only channels 1 and 3 valid (CHANNELS=4) → alternating out_chan 1,3,1,3 with no bubbles; in_ready[0] and in_ready[2] never high.
- out_ready=0 for 5 cycles while out_valid=1 (data 0x1234) → out_data stays 0x1234, in_ready=0 throughout, ptr frozen; release → next grant follows the frozen ptr.
- CHANNELS=3, all valid → out_chan 0,1,2,0,1,2; ptr never reaches 3.
- rst_n pulsed low asynchronously mid-stream with out_valid=1 → out_valid, out_data and out_chan are 0 immediately; the first grant after release goes to channel 0.
- SCHED_TDM_EN defined, only channel 2 valid → one grant every 4 cycles (out_chan=2); the other 3 cycles have out_valid=0 when out_ready=1.
